mult_div_engine: RTL and testbench
==================================

MULT_DIV_ENGINE -- requirements
Module: mult_div_engine

Interface
REQ-001 Parameter DATA_W, default 32: operand width; SHALL be even and >= 8.
REQ-002 Parameter MULT_LAT, default 2: cycles from accept to response for multiply ops; SHALL be >= 1.
REQ-003 Parameter DIV_STEP, default 2: quotient bits resolved per divide cycle; SHALL divide DATA_W.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous kill of any in-flight op.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  engine can accept a request.
REQ-009 op  in  3  operation code (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU).
REQ-010 operand_1, operand_2  in  DATA_W  source operands (dividend, divisor for divide).
REQ-011 hi_in, lo_in  in  DATA_W  accumulator for MADD/MSUB.
REQ-012 resp_valid  out  1  result available.
REQ-013 resp_ready  in  1  consumer takes result.
REQ-014 result  out  2*DATA_W  {hi, lo}; divide: {remainder, quotient}.
REQ-015 div_by_zero  out  1  qualifies result when resp_valid.

Function
REQ-016 FSM states IDLE, MUL, DIV, DONE; req_ready SHALL be 1 only in IDLE.
REQ-017 Accept = req_valid & req_ready & !flush; op, operands, hi_in, lo_in SHALL be captured at accept and later input changes SHALL be ignored.
REQ-018 IDLE->MUL or IDLE->DIV on accept; MUL->DONE after MULT_LAT cycles; DIV->DONE after DATA_W/DIV_STEP + 1 cycles (16 + 1 = 17 at defaults), counted from accept edge.
REQ-019 resp_valid SHALL be 1 exactly in DONE; result and div_by_zero SHALL hold stable there until resp_valid & resp_ready, then DONE->IDLE.
REQ-020 Signed ops: operands converted to magnitude; product/quotient negated when operand signs differ; remainder takes dividend's sign.
REQ-021 MADD: result = {hi,lo} + product; MSUB: result = {hi,lo} - product; both modulo 2^(2*DATA_W).
REQ-022 Divide by zero: quotient all ones, remainder = operand_1, div_by_zero = 1, same latency as normal divide.
REQ-023 Signed overflow (operand_1 = most-negative, operand_2 = -1): quotient = operand_1, remainder = 0, div_by_zero = 0.
REQ-024 flush SHALL return the FSM to IDLE on the next edge from any state, drop the pending result, and deassert resp_valid; no response SHALL ever be produced for a flushed op.
REQ-025 flush and req_valid high together in IDLE: no accept.
REQ-026 result SHALL read 0 whenever resp_valid is 0.

Reset
REQ-027 rst low SHALL immediately force IDLE, resp_valid = 0, result = 0, div_by_zero = 0, req_ready = 1 after release, clearing all counters.
REQ-028 rst asserted mid-operation SHALL abandon the op with no response after release.

Configuration
REQ-029 Macro MULT_DIV_ACC_EN: defined -> MADD/MADDU/MSUB/MSUBU per REQ-021; undefined -> accumulator adder and hi_in/lo_in usage removed, those ops complete as MULT/MULTU respectively (hi_in, lo_in ignored).

Structure
REQ-030 Package mult_div_pkg SHALL hold op encodings, FSM state type, and default parameter constants.
REQ-031 Sub-module div_iter SHALL implement the unsigned iterative divider (DIV_STEP bits/cycle, start/done, magnitude in, quotient/remainder out); sign handling and multiplier stay in mult_div_engine.

Verification
REQ-032 MULT 0xFFFFFFFE x 0x00000003, resp_ready=1 -> resp_valid 2 cycles after accept, result 0xFFFFFFFF_FFFFFFFA.
REQ-033 DIV 0xFFFFFFF9 / 0x00000002 -> 17 cycles, quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIVU same operands -> quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-034 DIVU 0x00000064 / 0 -> quotient 0xFFFFFFFF, remainder 0x00000064, div_by_zero 1; DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0.
REQ-035 MADD hi/lo = 0x00000000_00000001, 0xFFFFFFFF x 0x00000001 -> result 0x00000000_00000000 (with MULT_DIV_ACC_EN); without macro -> 0xFFFFFFFF_FFFFFFFF.
REQ-036 DIV accepted, flush at cycle 5 -> IDLE next edge, req_ready 1, no resp_valid; next MULTU 3 x 4 returns 0x0000000C.
REQ-037 resp_ready held 0 for 10 cycles in DONE -> result stable, req_ready 0, operand changes no effect; rst pulsed low mid-divide -> outputs 0 immediately.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared op encodings, FSM state type and default sizing for mult_div_engine.
// MULT_DIV_ACC_EN (engine build macro) enables the MADD/MSUB accumulator path.
package mult_div_pkg;

   localparam int MD_DATA_W   = 32;
   localparam int MD_MULT_LAT = 2;
   localparam int MD_DIV_STEP = 2;

   // Bit 0 set = unsigned variant; bit 2 = accumulate; bit 1 (with bit 2) = subtract.
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, DIV_STEP quotient bits per cycle.
// Divisor 0 naturally yields quotient all ones and remainder = dividend.
module div_iter
   import mult_div_pkg::*;
#(
   parameter int DATA_W   = MD_DATA_W,
   parameter int DIV_STEP = MD_DIV_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              kill,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int ITER  = DATA_W / DIV_STEP;
   localparam int CNT_W = $clog2(ITER + 1);

   logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [DATA_W:0]   sh;

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      sh     = '0;
      if (kill) begin
         busy_d = 1'b0;
      end else if (start) begin
         rem_d  = '0;
         quo_d  = dividend;
         dvs_d  = divisor;
         cnt_d  = CNT_W'(ITER);
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Quotient bits shift in from the bottom as dividend bits leave the top.
         for (int i = 0; i < DIV_STEP; i++) begin
            sh    = {rem_d, quo_d[DATA_W-1]};
            quo_d = {quo_d[DATA_W-2:0], 1'b0};
            if (sh >= {1'b0, dvs_d}) begin
               sh       = sh - {1'b0, dvs_d};
               quo_d[0] = 1'b1;
            end
            rem_d = sh[DATA_W-1:0];
         end
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign done      = ~busy_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/mult_div_engine.sv
// Multiply / divide / multiply-accumulate engine with valid-ready handshake.
// Define MULT_DIV_ACC_EN to enable MADD/MSUB accumulation; otherwise they act as MULT/MULTU.
module mult_div_engine
   import mult_div_pkg::*;
#(
   parameter int DATA_W   = MD_DATA_W,
   parameter int MULT_LAT = MD_MULT_LAT,
   parameter int DIV_STEP = MD_DIV_STEP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [2:0]          op,
   input  logic [DATA_W-1:0]   operand_1,
   input  logic [DATA_W-1:0]   operand_2,
   input  logic [DATA_W-1:0]   hi_in,
   input  logic [DATA_W-1:0]   lo_in,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [2*DATA_W-1:0] result,
   output logic                div_by_zero
);

   localparam int DIV_CYC = DATA_W / DIV_STEP + 1;
   localparam int CNT_MAX = (DIV_CYC > MULT_LAT) ? DIV_CYC : MULT_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          op_q;
   logic [DATA_W-1:0]   a_q, b_q;
   logic [2*DATA_W-1:0] result_q, result_d, res_calc;
   logic                dbz_q, dbz_d, dbz_calc;
   logic                accept, div_start, div_done;
   logic                a_neg, b_neg, in_a_neg, in_b_neg;
   logic [DATA_W-1:0]   a_mag, b_mag, in_a_mag, in_b_mag, quo, rem, q_fix, r_fix;
   logic [2*DATA_W-1:0] prod_mag, prod;

   assign accept = req_valid & req_ready & ~flush;

   // Divider loads magnitudes straight from the inputs so it starts on the accept edge.
   assign in_a_neg  = ~op[0] & operand_1[DATA_W-1];
   assign in_b_neg  = ~op[0] & operand_2[DATA_W-1];
   assign in_a_mag  = in_a_neg ? (~operand_1 + 1'b1) : operand_1;
   assign in_b_mag  = in_b_neg ? (~operand_2 + 1'b1) : operand_2;
   assign div_start = accept & op_is_div(op);

   div_iter #(.DATA_W(DATA_W), .DIV_STEP(DIV_STEP)) u_div (
      .clk       (clk),
      .rst       (rst),
      .kill      (flush),
      .start     (div_start),
      .dividend  (in_a_mag),
      .divisor   (in_b_mag),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rem)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = op_is_div(op) ? ST_DIV : ST_MUL;
         ST_MUL:  if (cnt_q == '0) state_d = ST_DONE;
         ST_DIV:  if (cnt_q == '0 && div_done) state_d = ST_DONE;
         ST_DONE: if (resp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_DONE);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept)
         cnt_d = op_is_div(op) ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_LAT - 1);
      else if ((state_q == ST_MUL || state_q == ST_DIV) && cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
      end else if (accept) begin
         op_q <= op;
         a_q  <= operand_1;
         b_q  <= operand_2;
      end
   end

   assign a_neg    = ~op_q[0] & a_q[DATA_W-1];
   assign b_neg    = ~op_q[0] & b_q[DATA_W-1];
   assign a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
   assign b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
   assign prod_mag = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
   assign prod     = (a_neg ^ b_neg) ? (~prod_mag + 1'b1) : prod_mag;
   assign q_fix    = (a_neg ^ b_neg) ? (~quo + 1'b1) : quo;
   assign r_fix    = a_neg ? (~rem + 1'b1) : rem;

`ifdef MULT_DIV_ACC_EN
   logic [2*DATA_W-1:0] acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        acc_q <= '0;
      else if (accept) acc_q <= {hi_in, lo_in};
   end
`else
   logic unused_acc;
   assign unused_acc = ^{hi_in, lo_in};
`endif

   always_comb begin
      res_calc = prod;
      dbz_calc = 1'b0;
      if (op_is_div(op_q)) begin
         // Zero divisor is reported with the raw dividend, not the sign-fixed remainder.
         if (b_q == '0) begin
            res_calc = {a_q, {DATA_W{1'b1}}};
            dbz_calc = 1'b1;
         end else begin
            res_calc = {r_fix, q_fix};
         end
      end
`ifdef MULT_DIV_ACC_EN
      else if (op_q[2]) begin
         res_calc = op_q[1] ? (acc_q - prod) : (acc_q + prod);
      end
`endif
   end

   always_comb begin
      result_d = result_q;
      dbz_d    = dbz_q;
      if (flush || (state_q == ST_DONE && resp_ready)) begin
         result_d = '0;
         dbz_d    = 1'b0;
      end else if (state_q != ST_DONE && state_d == ST_DONE) begin
         result_d = res_calc;
         dbz_d    = dbz_calc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         result_q <= result_d;
         dbz_q    <= dbz_d;
      end
   end

   assign result      = resp_valid ? result_q : '0;
   assign div_by_zero = resp_valid & dbz_q;

endmodule

// File: tb/tb_mult_div_engine.sv
// Directed self-checking bench for mult_div_engine at default parameters.
module tb_mult_div_engine;
   import mult_div_pkg::*;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst, flush, req_valid, req_ready, resp_valid, resp_ready, div_by_zero;
   logic [2:0]     op;
   logic [W-1:0]   operand_1, operand_2, hi_in, lo_in;
   logic [2*W-1:0] result;
   int             checks = 0;
   int             errors = 0;

   always #5 clk = ~clk;

   mult_div_engine dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .op          (op),
      .operand_1   (operand_1),
      .operand_2   (operand_2),
      .hi_in       (hi_in),
      .lo_in       (lo_in),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one request, holds it across the accept edge, then scrambles the inputs.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] h, input logic [W-1:0] l);
      @(negedge clk);
      op = o; operand_1 = a; operand_2 = b; hi_in = h; lo_in = l; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      op = 3'($urandom); operand_1 = $urandom; operand_2 = $urandom;
      hi_in = $urandom; lo_in = $urandom;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (!resp_valid && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] h, input logic [W-1:0] l,
                      input int lat, input logic [63:0] exp_res, input logic exp_dbz);
      int n;
      issue(o, a, b, h, l);
      wait_resp(n);
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " result"}, result, exp_res);
      check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
      @(posedge clk);
      #1;
      check({tag, " drop valid"}, 64'(resp_valid), 64'd0);
      check({tag, " result zero"}, result, 64'd0);
   endtask

   initial begin
      int n, ok;
      logic seen;
      logic [63:0] exp_madd, exp_msubu;

      rst = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      op = '0; operand_1 = '0; operand_2 = '0; hi_in = '0; lo_in = '0;
      #1;
      check("reset resp_valid", 64'(resp_valid), 64'd0);
      check("reset result", result, 64'd0);
      check("reset dbz", 64'(div_by_zero), 64'd0);
      #19 rst = 1'b1;
      #1 check("reset req_ready", 64'(req_ready), 64'd1);

      run("mult", OP_MULT, 32'hFFFFFFFE, 32'h3, 0, 0, 2, 64'hFFFFFFFF_FFFFFFFA, 1'b0);
      run("mult negneg", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 0, 0, 2, 64'h0000000F, 1'b0);
      run("div", OP_DIV, 32'hFFFFFFF9, 32'h2, 0, 0, 17, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
      run("divu", OP_DIVU, 32'hFFFFFFF9, 32'h2, 0, 0, 17, 64'h00000001_7FFFFFFC, 1'b0);
      run("divu by zero", OP_DIVU, 32'h64, 32'h0, 0, 0, 17, 64'h00000064_FFFFFFFF, 1'b1);
      run("div overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 17,
          64'h00000000_80000000, 1'b0);

`ifdef MULT_DIV_ACC_EN
      exp_madd  = 64'h0;
      exp_msubu = 64'hFFFFFFFF_FFFFFFFA;
`else
      exp_madd  = 64'hFFFFFFFF_FFFFFFFF;
      exp_msubu = 64'h6;
`endif
      run("madd", OP_MADD, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 2, exp_madd, 1'b0);
      run("msubu", OP_MSUBU, 32'h2, 32'h3, 32'h0, 32'h0, 2, exp_msubu, 1'b0);

      // Flush a divide mid-flight.
      issue(OP_DIV, 32'd100, 32'd7, 0, 0);
      repeat (4) @(posedge clk);
      @(negedge clk) flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush req_ready", 64'(req_ready), 64'd1);
      check("flush resp_valid", 64'(resp_valid), 64'd0);
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1 seen = seen | resp_valid;
      end
      check("flush no response", 64'(seen), 64'd0);
      run("multu after flush", OP_MULTU, 32'd3, 32'd4, 0, 0, 2, 64'h0000000C, 1'b0);

      // flush together with req_valid in IDLE must not accept.
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; op = OP_MULTU; operand_1 = 32'd9; operand_2 = 32'd9;
      @(posedge clk);
      #1 flush = 1'b0; req_valid = 1'b0;
      check("flush+req no accept", 64'(req_ready), 64'd1);
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1 seen = seen | resp_valid;
      end
      check("flush+req no response", 64'(seen), 64'd0);

      // Backpressure: DONE holds while resp_ready is low.
      resp_ready = 1'b0;
      issue(OP_MULTU, 32'd5, 32'd7, 0, 0);
      wait_resp(n);
      check("hold latency", 64'(n), 64'd2);
      ok = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (resp_valid && !req_ready && result === 64'h23) ok++;
         operand_1 = $urandom; operand_2 = $urandom; req_valid = 1'b1;
      end
      req_valid = 1'b0;
      check("hold stable cycles", 64'(ok), 64'd10);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold release valid", 64'(resp_valid), 64'd0);
      check("hold release result", result, 64'd0);

      // Reset while a result is held must clear outputs at once.
      resp_ready = 1'b0;
      issue(OP_DIVU, 32'h64, 32'h0, 0, 0);
      wait_resp(n);
      check("dbz hold latency", 64'(n), 64'd17);
      #2 rst = 1'b0;
      #1;
      check("rst in done valid", 64'(resp_valid), 64'd0);
      check("rst in done result", result, 64'd0);
      check("rst in done dbz", 64'(div_by_zero), 64'd0);
      @(negedge clk) rst = 1'b1;
      resp_ready = 1'b1;

      // Reset mid-divide abandons the op.
      issue(OP_DIV, 32'd1000, 32'd3, 0, 0);
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst mid-div req_ready", 64'(req_ready), 64'd1);
      check("rst mid-div valid", 64'(resp_valid), 64'd0);
      check("rst mid-div result", result, 64'd0);
      @(negedge clk) rst = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1 seen = seen | resp_valid;
      end
      check("rst mid-div no response", 64'(seen), 64'd0);
      run("div after reset", OP_DIV, 32'd100, 32'hFFFFFFF9, 0, 0, 17,
          64'h00000002_FFFFFFF2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
